// File: rtl/multi_key_debounce.sv
// ============================================================================
// multi_key_debounce
//
// Debounces CH independent key inputs and derives press / release / long-hold
// / auto-repeat events for each one. A single prescaler produces a 1 ms tick
// shared by all channels; debounce and hold timing are counted in ms ticks.
//
// Parameters
//   CH          number of key channels (1..32)
//   FREQ        clock frequency in MHz
//   DEBOUNCE_MS stable time required before a level change is accepted
//   LONG_MS     hold time after the accepted press before key_long fires
//   REPEAT_MS   auto-repeat period after key_long (0 = no repeat)
//   IDLE_LEVEL  raw level of a released key (1 = active-low buttons)
//
// Ports
//   clk          clock for all logic
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous key levels, bit i = channel i
//   key_state    debounced state, 1 = pressed
//   key_press    one-cycle pulse on accepted press
//   key_release  one-cycle pulse on accepted release
//   key_long     one-cycle pulse when the hold reaches LONG_MS
//   key_repeat   one-cycle pulse every REPEAT_MS after key_long while held
//   any_pressed  OR of key_state
// ============================================================================
module multi_key_debounce #(
    parameter int CH          = 4,
    parameter int FREQ        = 50,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int IDLE_LEVEL  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] key_in,
    output logic [CH-1:0] key_state,
    output logic [CH-1:0] key_press,
    output logic [CH-1:0] key_release,
    output logic [CH-1:0] key_long,
    output logic [CH-1:0] key_repeat,
    output logic          any_pressed
);

    localparam int   PRE_MAX  = FREQ * 1000 - 1;
    localparam int   PRE_W    = (FREQ * 1000 > 1) ? $clog2(FREQ * 1000) : 1;
    localparam int   HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int   HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int   DB_W     = $clog2(DEBOUNCE_MS + 1);
    localparam int   LONG_LAST = LONG_MS - 1;
    localparam int   RPT_LAST  = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
    localparam bit   RPT_EN    = (REPEAT_MS > 0);
    localparam logic IDLE_BIT  = (IDLE_LEVEL != 0);

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_HELD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Shared 1 ms prescaler
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt_reg;
    logic             ms_tick;

    assign ms_tick = (pre_cnt_reg == PRE_W'(PRE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg <= '0;
        end else if (ms_tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchronisers, idle level out of reset so a released key
    // never looks like a change
    // ------------------------------------------------------------------
    logic [CH-1:0] sync1_reg;
    logic [CH-1:0] sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= {CH{IDLE_BIT}};
            sync2_reg <= {CH{IDLE_BIT}};
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Pressed/released view of every channel after this edge; feeds the
    // registered OR so any_pressed moves in the same cycle as key_state.
    logic [CH-1:0] pressed_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |pressed_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce and hold FSM
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [DB_W-1:0]   db_cnt_reg;
            logic              db_lvl_reg;
            logic              state_bit_reg;
            logic              press_reg;
            logic              release_reg;
            logic              long_reg;
            logic              rpt_reg;
            logic              differs;
            logic              accept;
            logic              press_evt;
            logic              release_evt;
            state_t            state_reg;
            state_t            state_next;
            logic [HOLD_W-1:0] hold_cnt_reg;
            logic [HOLD_W-1:0] hold_cnt_next;
            logic              long_next;
            logic              rpt_next;

            assign differs     = (sync2_reg[gi] != db_lvl_reg);
            assign accept      = differs && ms_tick &&
                                 (db_cnt_reg == DB_W'(DEBOUNCE_MS - 1));
            assign press_evt   = accept && (sync2_reg[gi] != IDLE_BIT);
            assign release_evt = accept && (sync2_reg[gi] == IDLE_BIT);

            // Any cycle in which the synchronised level matches the accepted
            // level restarts the debounce interval from zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    db_cnt_reg    <= '0;
                    db_lvl_reg    <= IDLE_BIT;
                    state_bit_reg <= 1'b0;
                    press_reg     <= 1'b0;
                    release_reg   <= 1'b0;
                end else begin
                    press_reg   <= press_evt;
                    release_reg <= release_evt;
                    if (!differs) begin
                        db_cnt_reg <= '0;
                    end else if (ms_tick) begin
                        if (accept) begin
                            db_lvl_reg    <= sync2_reg[gi];
                            db_cnt_reg    <= '0;
                            state_bit_reg <= (sync2_reg[gi] != IDLE_BIT);
                        end else begin
                            db_cnt_reg <= db_cnt_reg + DB_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg    <= ST_REL;
                    hold_cnt_reg <= '0;
                    long_reg     <= 1'b0;
                    rpt_reg      <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    hold_cnt_reg <= hold_cnt_next;
                    long_reg     <= long_next;
                    rpt_reg      <= rpt_next;
                end
            end

            // hold_cnt only increments while below its threshold and clears
            // on reaching it, so it can never pass HOLD_MAX. An accepted
            // release takes priority over a long/repeat due in the same tick.
            always_comb begin
                state_next    = state_reg;
                hold_cnt_next = hold_cnt_reg;
                long_next     = 1'b0;
                rpt_next      = 1'b0;
                case (state_reg)
                    ST_REL: begin
                        if (press_evt) begin
                            state_next    = ST_HELD;
                            hold_cnt_next = '0;
                        end
                    end
                    ST_HELD: begin
                        if (release_evt) begin
                            state_next    = ST_REL;
                            hold_cnt_next = '0;
                        end else if (ms_tick) begin
                            if (hold_cnt_reg >= HOLD_W'(LONG_LAST)) begin
                                state_next    = ST_RPT;
                                hold_cnt_next = '0;
                                long_next     = 1'b1;
                            end else begin
                                hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                            end
                        end
                    end
                    ST_RPT: begin
                        if (release_evt) begin
                            state_next    = ST_REL;
                            hold_cnt_next = '0;
                        end else if (ms_tick && RPT_EN) begin
                            if (hold_cnt_reg >= HOLD_W'(RPT_LAST)) begin
                                hold_cnt_next = '0;
                                rpt_next      = 1'b1;
                            end else begin
                                hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_next    = ST_REL;
                        hold_cnt_next = '0;
                    end
                endcase
            end

            assign pressed_next[gi] = (state_next != ST_REL);
            assign key_state[gi]    = state_bit_reg;
            assign key_press[gi]    = press_reg;
            assign key_release[gi]  = release_reg;
            assign key_long[gi]     = long_reg;
            assign key_repeat[gi]   = rpt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_key_debounce.sv
// ============================================================================
// tb_multi_key_debounce
//
// Directed bench for multi_key_debounce at FREQ=1 (1 ms = 1000 clk),
// DEBOUNCE_MS=2, LONG_MS=5, REPEAT_MS=2, CH=4, plus a one-channel
// REPEAT_MS=0 instance. Ticks act on edges 1000, 2000, ... counted from the
// edge at which reset is released; all stimulus changes are aligned to that.
// ============================================================================
module tb_multi_key_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'b1111;
    logic [3:0] key_state, key_press, key_release, key_long, key_repeat;
    logic       any_pressed;

    logic       key2 = 1'b1;
    logic       k2_state, k2_press, k2_release, k2_long, k2_repeat, k2_any;

    always #5 clk = ~clk;

    multi_key_debounce #(
        .CH(4), .FREQ(1), .DEBOUNCE_MS(2), .LONG_MS(5), .REPEAT_MS(2), .IDLE_LEVEL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat), .any_pressed(any_pressed)
    );

    multi_key_debounce #(
        .CH(1), .FREQ(1), .DEBOUNCE_MS(2), .LONG_MS(5), .REPEAT_MS(0), .IDLE_LEVEL(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .key_in(key2),
        .key_state(k2_state), .key_press(k2_press), .key_release(k2_release),
        .key_long(k2_long), .key_repeat(k2_repeat), .any_pressed(k2_any)
    );

    // Edge count since the last reset release (edge 0 = last edge in reset).
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Event monitor
    // ------------------------------------------------------------------
    int n_press[4] = '{default: 0};
    int n_rel[4]   = '{default: 0};
    int n_long[4]  = '{default: 0};
    int n_rpt[4]   = '{default: 0};
    int last_press[4] = '{default: 0};
    int last_long[4]  = '{default: 0};
    int last_rpt[4]   = '{default: 0};
    int prev_rpt[4]   = '{default: 0};
    int excl_viol = 0;
    int any_viol  = 0;
    int n2_press = 0, n2_rel = 0, n2_long = 0, n2_rpt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (key_press[i]) begin
                n_press[i]    <= n_press[i] + 1;
                last_press[i] <= cyc;
            end
            if (key_release[i]) n_rel[i] <= n_rel[i] + 1;
            if (key_long[i]) begin
                n_long[i]    <= n_long[i] + 1;
                last_long[i] <= cyc;
            end
            if (key_repeat[i]) begin
                n_rpt[i]    <= n_rpt[i] + 1;
                prev_rpt[i] <= last_rpt[i];
                last_rpt[i] <= cyc;
            end
            if ((32'(key_press[i]) + 32'(key_release[i]) + 32'(key_long[i]) +
                 32'(key_repeat[i])) > 1)
                excl_viol <= excl_viol + 1;
        end
        if (any_pressed != (|key_state)) any_viol <= any_viol + 1;
        if (k2_press)   n2_press <= n2_press + 1;
        if (k2_release) n2_rel   <= n2_rel + 1;
        if (k2_long)    n2_long  <= n2_long + 1;
        if (k2_repeat)  n2_rpt   <= n2_rpt + 1;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Vector record: keys applied for `cycles` edges, then the debounced
    // state and the per-channel event counts (nibble per channel, ch3 high)
    // seen during that interval are compared.
    typedef struct packed {
        logic [3:0]  keys;
        logic [31:0] cycles;
        logic [3:0]  st;
        logic [15:0] press;
        logic [15:0] rel;
        logic [15:0] lng;
        logic [15:0] rpt;
    } vec_t;

    vec_t vecs [10];

    int s_press[4], s_rel[4], s_long[4], s_rpt[4];
    logic [15:0] dp, dr, dl, dt;
    int vstart;

    task automatic snap();
        s_press = n_press;
        s_rel   = n_rel;
        s_long  = n_long;
        s_rpt   = n_rpt;
    endtask

    task automatic deltas();
        for (int c = 0; c < 4; c++) begin
            dp[c*4 +: 4] = 4'(n_press[c] - s_press[c]);
            dr[c*4 +: 4] = 4'(n_rel[c]   - s_rel[c]);
            dl[c*4 +: 4] = 4'(n_long[c]  - s_long[c]);
            dt[c*4 +: 4] = 4'(n_rpt[c]   - s_rpt[c]);
        end
    endtask

    initial begin
        //            keys     cycles     state    press     rel       long      repeat
        vecs[0] = '{4'b1111, 32'd3000,  4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}; // idle
        vecs[1] = '{4'b1101, 32'd1500,  4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}; // ch1 bounce
        vecs[2] = '{4'b1111, 32'd2500,  4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}; // bounce ends
        vecs[3] = '{4'b1110, 32'd3000,  4'b0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000}; // ch0 press
        vecs[4] = '{4'b1111, 32'd3000,  4'b0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000}; // ch0 short release
        vecs[5] = '{4'b1011, 32'd20000, 4'b0100, 16'h0100, 16'h0000, 16'h0100, 16'h0600}; // ch2 long hold
        vecs[6] = '{4'b1111, 32'd4000,  4'b0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100}; // ch2 release
        vecs[7] = '{4'b0110, 32'd3000,  4'b1001, 16'h1001, 16'h0000, 16'h0000, 16'h0000}; // ch0+ch3 press
        vecs[8] = '{4'b0110, 32'd7500,  4'b1001, 16'h0000, 16'h0000, 16'h1001, 16'h1001}; // ch0+ch3 hold
        vecs[9] = '{4'b1111, 32'd4000,  4'b0000, 16'h0000, 16'h1001, 16'h0000, 16'h1001}; // both release

        // Reset state, with reset held from time zero
        #7;
        chk("rst_key_state", 32'(key_state), 32'd0);
        chk("rst_pulses", 32'({key_press, key_release, key_long, key_repeat}), 32'd0);
        chk("rst_any_pressed", 32'(any_pressed), 32'd0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;                 // cyc = 0 here
        key2 = 1'b0;                      // REPEAT_MS=0 instance held from now on

        for (int v = 0; v < 10; v++) begin
            key_in = vecs[v].keys;
            vstart = cyc;
            snap();
            repeat (int'(vecs[v].cycles)) @(posedge clk);
            #1;
            deltas();
            $display("vec %0d @%0d keys=%b cycles=%0d state=%b press=%h rel=%h long=%h rpt=%h",
                     v, vstart, vecs[v].keys, vecs[v].cycles, key_state, dp, dr, dl, dt);
            chk($sformatf("v%0d_state", v), 32'(key_state), 32'(vecs[v].st));
            chk($sformatf("v%0d_press", v), 32'(dp), 32'(vecs[v].press));
            chk($sformatf("v%0d_release", v), 32'(dr), 32'(vecs[v].rel));
            chk($sformatf("v%0d_long", v), 32'(dl), 32'(vecs[v].lng));
            chk($sformatf("v%0d_repeat", v), 32'(dt), 32'(vecs[v].rpt));
            if (v == 3)
                chk_range("press_latency_ch0", last_press[0] - vstart, 1001, 2003);
            if (v == 5) begin
                chk("long_after_press_ch2", 32'(last_long[2] - last_press[2]), 32'd5000);
                chk("repeat_period_ch2", 32'(last_rpt[2] - prev_rpt[2]), 32'd2000);
            end
            if (v == 6) begin
                chk("r0_state", 32'(k2_state), 32'd1);
                chk("r0_press", 32'(n2_press), 32'd1);
                chk("r0_long", 32'(n2_long), 32'd1);
                chk("r0_repeat", 32'(n2_rpt), 32'd0);
                key2 = 1'b1;
            end
            if (v == 7)
                chk("simul_press_ch0_ch3", 32'(last_press[0] - last_press[3]), 32'd0);
            if (v == 9) begin
                chk("r0_release", 32'(n2_rel), 32'd1);
                chk("r0_state_rel", 32'(k2_state), 32'd0);
                chk("r0_repeat_final", 32'(n2_rpt), 32'd0);
            end
        end

        // Reset during RPT: ch2 pressed at cyc 51500, accepted at 53000,
        // key_long pulse visible just after edge 58000.
        key_in = 4'b1011;
        repeat (6500) @(posedge clk);
        #1;
        $display("seq reset_in_rpt @%0d key_long=%b key_state=%b", cyc, key_long, key_state);
        chk("pre_rst_long_ch2", 32'(key_long), 32'h4);
        chk("pre_rst_state", 32'(key_state), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(key_state), 32'd0);
        chk("mid_rst_pulses", 32'({key_press, key_release, key_long, key_repeat}), 32'd0);
        chk("mid_rst_any", 32'(any_pressed), 32'd0);
        snap();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;                 // cyc = 0 here, ch2 still held

        repeat (2500) @(posedge clk);
        #1;
        deltas();
        $display("seq re_press @%0d state=%b press=%h long=%h", cyc, key_state, dp, dl);
        chk("re_press_count", 32'(dp), 32'h0100);
        chk_range("re_press_latency", last_press[2], 1001, 2003);
        chk("re_press_state", 32'(key_state), 32'h4);
        chk("re_press_any", 32'(any_pressed), 32'd1);

        repeat (5000) @(posedge clk);
        #1;
        deltas();
        $display("seq re_long @%0d long=%h repeat=%h", cyc, dl, dt);
        chk("re_long_count", 32'(dl), 32'h0100);
        chk("re_long_delay", 32'(last_long[2] - last_press[2]), 32'd5000);
        chk("re_release_none", 32'(dr), 32'd0);
        chk("re_repeat_none", 32'(dt), 32'd0);

        chk("exclusive_pulses", 32'(excl_viol), 32'd0);
        chk("any_pressed_tracks_state", 32'(any_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
